sigmoid_fold_stream: RTL and testbench

Streaming wrapper placed directly around the existing `pwla_sigmoid` core. It accepts signed Q5.10 activations over a valid/ready handshake and folds negative inputs onto the positive half-axis (|x| into the core, `1 - f` out). It also clamps out-of-range inputs to exact 0/1 and buffers results so downstream back-pressure never stalls the free-running core. This moves the sign handling that benches currently do by hand into RTL, so neuron datapaths can consume the sigmoid stage directly.

---
 rtl/sigmoid_pkg.sv | 29 ++
 rtl/pwla_sigmoid.sv | 31 +++
 rtl/sigmoid_out_fifo.sv | 59 +++++
 rtl/sigmoid_fold_stream.sv | 114 +++++++++++
 tb/tb_sigmoid_fold_stream.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sigmoid_pkg.sv
// Shared types and constants for the sigmoid streaming stage.
//   q5_10_t  : signed Q5.10 activation
//   uq6_10_t : unsigned Q6.10 sigmoid value, 1.0 == FX_ONE
//   side_t   : per-token sideband that travels alongside the core
package sigmoid_pkg;

  typedef logic signed [15:0] q5_10_t;
  typedef logic [15:0]        uq6_10_t;

  localparam int unsigned FRAC_BITS       = 10;
  localparam uq6_10_t     FX_ONE          = 16'd1024;
  localparam uq6_10_t     SAT_LIM_DEFAULT = 16'd8192;

  typedef struct packed {
    logic valid;
    logic sign;
    logic sat;
  } side_t;

  // |x| with the single unrepresentable case (-32.0) pinned to the largest magnitude.
  function automatic uq6_10_t fold_mag(input q5_10_t x);
    logic [15:0] ux;
    ux = x;
    if (!ux[15])            return ux;
    else if (ux == 16'h8000) return 16'h7FFF;
    else                    return ~ux + 16'd1;
  endfunction

endpackage

// File: rtl/pwla_sigmoid.sv
// Piecewise-linear sigmoid core for non-negative Q.10 inputs, one register stage.
//   clk : clock
//   x   : non-negative magnitude, Q.10
//   f_x : sigmoid(x) approximation, Q.10, valid one cycle after x
module pwla_sigmoid
  import sigmoid_pkg::*;
(
  input  logic        clk,
  input  logic [15:0] x,
  output logic [15:0] f_x
);

  localparam logic [15:0] Seg1 = 16'(1 << FRAC_BITS);  // 1.0
  localparam logic [15:0] Seg2 = 16'd2432;             // 2.375
  localparam logic [15:0] Seg3 = 16'd5120;             // 5.0

  logic [15:0] f_d;

  always_comb begin
    f_d = FX_ONE;
    if (x >= Seg3)      f_d = FX_ONE;
    else if (x >= Seg2) f_d = (x >> 5) + 16'd864;
    else if (x >= Seg1) f_d = (x >> 3) + 16'd640;
    else                f_d = (x >> 2) + 16'd512;
  end

  always_ff @(posedge clk) begin
    f_x <= f_d;
  end

endmodule

// File: rtl/sigmoid_out_fifo.sv
// First-word-fall-through FIFO; rdata_o shows the head whenever !empty_o, else 0.
//   push_i/wdata_i : write (ignored when full)
//   pop_i          : consume head (ignored when empty)
//   count_o/empty_o/full_o : occupancy status
module sigmoid_out_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sigmoid_fold_stream.sv
// Streaming sigmoid: folds negative inputs onto |x|, runs the free-running core,
// clamps |x| >= SAT_LIM to exact 0/1 and buffers results in a credit-managed FIFO.
//   in_valid/in_ready/in_x    : signed Q5.10 input handshake
//   out_valid/out_ready/out_y : unsigned Q6.10 result handshake, out_y in [0, 1024]
module sigmoid_fold_stream
  import sigmoid_pkg::*;
#(
  parameter int unsigned CORE_LAT = 1,
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] SAT_LIM  = SAT_LIM_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_y
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            accept;
  logic [15:0]     mag_d;
  side_t           s0_q;
  logic [15:0]     s0_mag_q;
  side_t           sb_q [CORE_LAT];
  logic [15:0]     core_x, core_f;
  logic [15:0]     raw, y_d;
  logic            s1_valid_q;
  logic [15:0]     s1_y_q;
  logic [CntW-1:0] fifo_count, inflight;
  logic [CntW:0]   total;
  logic            fifo_empty, fifo_full;

  assign accept = in_valid && in_ready;
  assign mag_d  = fold_mag(in_x);

  // S0: one-cycle stage; tokens never stall since the core cannot be paused.
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q     <= '0;
      s0_mag_q <= '0;
    end else begin
      s0_q.valid <= accept;
      s0_q.sign  <= in_x[15];
      s0_q.sat   <= (mag_d >= SAT_LIM);
      s0_mag_q   <= mag_d;
    end
  end

  assign core_x = s0_q.valid ? s0_mag_q : '0;

  pwla_sigmoid u_core (
    .clk (clk),
    .x   (core_x),
    .f_x (core_f)
  );

  // Sideband delay line matched to the core latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CORE_LAT; i++) sb_q[i] <= '0;
    end else begin
      sb_q[0] <= s0_q;
      for (int i = 1; i < CORE_LAT; i++) sb_q[i] <= sb_q[i-1];
    end
  end

  // S1 fold: result is 1 - f for negative inputs; raw is capped so this cannot wrap.
  always_comb begin
    raw = core_f;
    if (sb_q[CORE_LAT-1].sat || (core_f > FX_ONE)) raw = FX_ONE;
    y_d = sb_q[CORE_LAT-1].sign ? FX_ONE - raw : raw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_y_q     <= '0;
    end else begin
      s1_valid_q <= sb_q[CORE_LAT-1].valid;
      s1_y_q     <= y_d;
    end
  end

  sigmoid_out_fifo #(
    .Depth (DEPTH),
    .Width (16)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (s1_valid_q),
    .wdata_i (s1_y_q),
    .pop_i   (out_ready),
    .rdata_o (out_y),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign out_valid = !fifo_empty;

  // Credit check: every token already in the pipe owns a FIFO slot.
  always_comb begin
    inflight = CntW'(s0_q.valid) + CntW'(s1_valid_q);
    for (int i = 0; i < CORE_LAT; i++) inflight = inflight + CntW'(sb_q[i].valid);
    total = {1'b0, fifo_count} + {1'b0, inflight};
  end

  assign in_ready = !reset && !fifo_full && (total < (CntW + 1)'(DEPTH));

endmodule

// File: tb/tb_sigmoid_fold_stream.sv
module tb_sigmoid_fold_stream;

  localparam int CORE_LAT = 1;
  localparam int DEPTH    = 8;
  localparam int NV       = 16;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_y;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_emit = 0;
  int          cyc = 0;
  bit          rnd_rdy = 1'b0;
  logic [15:0] exp_q [$];
  vec_t        tbl [NV];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sigmoid_fold_stream #(
    .CORE_LAT (CORE_LAT),
    .DEPTH    (DEPTH),
    .SAT_LIM  (16'd8192)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y)
  );

  function automatic logic [15:0] core_ref(input logic [15:0] m);
    if (m >= 16'd5120) return 16'd1024;
    if (m >= 16'd2432) return (m >> 5) + 16'd864;
    if (m >= 16'd1024) return (m >> 3) + 16'd640;
    return (m >> 2) + 16'd512;
  endfunction

  function automatic logic [15:0] model(input logic [15:0] x);
    logic [15:0] mag, f, raw;
    mag = !x[15] ? x : (x == 16'h8000) ? 16'h7FFF : 16'd0 - x;
    f   = core_ref(mag);
    raw = (mag >= 16'd8192 || f > 16'd1024) ? 16'd1024 : f;
    return x[15] ? 16'd1024 - raw : raw;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Scoreboard consumer: every emit pops the oldest expected result.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_emit++;
      if (exp_q.size() == 0) check("unexpected_output", int'(out_y), -1);
      else check("out_y", int'(out_y), int'(exp_q.pop_front()));
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Present x until accepted; expected result enters the scoreboard on accept.
  task automatic send(input logic [15:0] x, input logic [15:0] e);
    bit ok;
    ok = 1'b0;
    in_x = x;
    in_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      check("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic lat_check(input logic [15:0] x, input logic [15:0] e);
    int n;
    send(x, e);
    in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    check("latency", n, CORE_LAT + 3);
  endtask

  initial begin
    logic [15:0] bp_x [10];
    int   acc, k, e0, c0, hi;
    real  mae, xr, ref_s;

    tbl = '{'{16'h0000, 16'd512},  '{16'h0800, 16'd896},  '{16'hF800, 16'd128},
            '{16'h2400, 16'd1024}, '{16'hDC00, 16'd0},    '{16'h8000, 16'd0},
            '{16'h0400, 16'd768},  '{16'hFC00, 16'd256},  '{16'h1FFF, 16'd1024},
            '{16'hE001, 16'd0},    '{16'h2000, 16'd1024}, '{16'h0BB8, 16'd957},
            '{16'hF448, 16'd67},   '{16'h0200, 16'd640},  '{16'h0980, 16'd940},
            '{16'hF680, 16'd84}};

    // Reset state
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_y", int'(out_y), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Zero input with nominal latency
    lat_check(16'h0000, 16'd512);
    drain();

    // Table vectors back-to-back; must be accepted one per cycle
    c0 = cyc;
    for (int i = 0; i < NV; i++) send(tbl[i].x, tbl[i].y);
    check("throughput_cycles", cyc - c0, NV);
    drain();

    // Back-pressure: 10 inputs against a stalled consumer
    for (int i = 0; i < 10; i++) bp_x[i] = 16'(i * 1200 - 5000);
    out_ready = 1'b0;
    acc = 0;
    k = 0;
    in_x = bp_x[0];
    in_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(bp_x[k]));
        acc++;
        k++;
      end
      @(posedge clk);
      #1;
      if (k < 10) in_x = bp_x[k];
      else in_valid = 1'b0;
    end
    check("bp_accepted", acc, DEPTH);
    check("bp_in_ready_low", int'(in_ready), 0);
    e0 = n_emit;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_before_emit", int'(in_ready), 0);
    @(posedge clk);
    #1;
    for (int c = 0; c < 60 && k < 10; c++) begin
      @(negedge clk);
      if (c == 0) check("bp_ready_after_emit", int'(in_ready), 1);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(bp_x[k]));
        k++;
      end
      @(posedge clk);
      #1;
      if (k < 10) in_x = bp_x[k];
      else in_valid = 1'b0;
    end
    drain();
    check("bp_emit_count", n_emit - e0, 10);

    // Sweep -8.0 .. +8.0 with random consumer readiness
    mae = 0.0;
    rnd_rdy = 1'b1;
    for (int v = -8192; v <= 8192; v += 16) begin
      send(16'(v), model(16'(v)));
      xr = real'(v) / 1024.0;
      ref_s = 1.0 / (1.0 + $exp(-xr));
      xr = real'(model(16'(v))) / 1024.0 - ref_s;
      mae += (xr < 0.0) ? -xr : xr;
    end
    drain();
    rnd_rdy = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 out_ready = 1'b1;
    $display("sweep mean abs error vs sigmoid: %f", mae / 1025.0);

    // Reset with 3 tokens in flight and 2 buffered
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(16'(i * 300), model(16'(i * 300)));
    in_valid = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) hi++;
    end
    check("post_rst_out_valid_cycles", hi, 0);
    @(posedge clk);
    #1;
    lat_check(16'hF800, 16'd128);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
